// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, funct3 encodings, legality check.
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] LSU_LB  = 3'b000;
    localparam logic [2:0] LSU_LH  = 3'b001;
    localparam logic [2:0] LSU_LW  = 3'b010;
    localparam logic [2:0] LSU_LD  = 3'b011;
    localparam logic [2:0] LSU_LBU = 3'b100;
    localparam logic [2:0] LSU_LHU = 3'b101;
    localparam logic [2:0] LSU_LWU = 3'b110;

    localparam logic [2:0] LSU_SB  = 3'b000;
    localparam logic [2:0] LSU_SH  = 3'b001;
    localparam logic [2:0] LSU_SW  = 3'b010;
    localparam logic [2:0] LSU_SD  = 3'b011;

    // Illegal encoding or an offset that is not a multiple of the access size.
    function automatic logic lsu_access_err(input logic       wen,
                                            input logic [2:0] funct3,
                                            input logic [2:0] off);
        logic illegal;
        logic misal;
        if (wen)
            illegal = !(funct3 inside {LSU_SB, LSU_SH, LSU_SW, LSU_SD});
        else
            illegal = (funct3 == 3'b111);
        case (funct3[1:0])
            2'b00:   misal = 1'b0;
            2'b01:   misal = off[0];
            2'b10:   misal = |off[1:0];
            default: misal = |off;
        endcase
        return illegal | misal;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane alignment: store data/mask placement and load extract/extend.
// Zero latency; no flow control of its own.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int MASK_W = 8
) (
    input  logic [2:0]        st_off_i,
    input  logic [1:0]        st_size_i,
    input  logic [XLEN-1:0]   st_wdata_i,
    output logic [XLEN-1:0]   st_wdata_o,
    output logic [MASK_W-1:0] st_wmask_o,
    input  logic [2:0]        ld_off_i,
    input  logic [2:0]        ld_funct3_i,
    input  logic [XLEN-1:0]   ld_rdata_i,
    output logic [XLEN-1:0]   ld_data_o
);

    logic [5:0]        st_shamt;
    logic [5:0]        ld_shamt;
    logic [MASK_W-1:0] base_mask;
    logic [XLEN-1:0]   ld_shifted;

    assign st_shamt   = {st_off_i, 3'b000};
    assign ld_shamt   = {ld_off_i, 3'b000};
    assign st_wdata_o = st_wdata_i << st_shamt;
    assign st_wmask_o = base_mask << st_off_i;
    assign ld_shifted = ld_rdata_i >> ld_shamt;

    always_comb begin
        base_mask = '1;
        case (st_size_i)
            2'b00:   base_mask = MASK_W'(1);
            2'b01:   base_mask = MASK_W'(3);
            2'b10:   base_mask = MASK_W'(15);
            default: base_mask = '1;
        endcase
    end

    always_comb begin
        ld_data_o = '0;
        case (ld_funct3_i)
            LSU_LB:  ld_data_o = {{(XLEN-8){ld_shifted[7]}},   ld_shifted[7:0]};
            LSU_LH:  ld_data_o = {{(XLEN-16){ld_shifted[15]}}, ld_shifted[15:0]};
            LSU_LW:  ld_data_o = {{(XLEN-32){ld_shifted[31]}}, ld_shifted[31:0]};
            LSU_LD:  ld_data_o = ld_shifted;
            LSU_LBU: ld_data_o = {{(XLEN-8){1'b0}},  ld_shifted[7:0]};
            LSU_LHU: ld_data_o = {{(XLEN-16){1'b0}}, ld_shifted[15:0]};
            LSU_LWU: ld_data_o = {{(XLEN-32){1'b0}}, ld_shifted[31:0]};
            default: ld_data_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: registered valid/ready request, waits for response, pulses lsu_done.
// Latency 3 cycles at zero-wait memory (1 on error); holds request until mem_req_ready.
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int MASK_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_valid,
    input  logic              lsu_wen,
    input  logic [2:0]        lsu_funct3,
    input  logic [XLEN-1:0]   lsu_addr,
    input  logic [XLEN-1:0]   lsu_wdata,
    output logic [XLEN-1:0]   lsu_rdata,
    output logic              lsu_done,
    output logic              lsu_err,
    output logic              lsu_stall,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_req_addr,
    output logic              mem_req_wen,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [MASK_W-1:0] mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_rdata
);

    lsu_state_e        state_q;
    logic              req_vld_q;
    logic              req_wen_q;
    logic [XLEN-1:0]   req_addr_q;
    logic [XLEN-1:0]   req_wdata_q;
    logic [MASK_W-1:0] req_wmask_q;
    logic [2:0]        off_q;
    logic [2:0]        funct3_q;
    logic              done_q;
    logic              err_q;
    logic [XLEN-1:0]   rdata_q;

    logic              access_err_d;
    logic [XLEN-1:0]   wdata_d;
    logic [MASK_W-1:0] wmask_d;
    logic [XLEN-1:0]   ld_data_d;

    assign access_err_d = lsu_access_err(lsu_wen, lsu_funct3, lsu_addr[2:0]);

    lsu_align #(
        .XLEN   (XLEN),
        .MASK_W (MASK_W)
    ) u_align (
        .st_off_i    (lsu_addr[2:0]),
        .st_size_i   (lsu_funct3[1:0]),
        .st_wdata_i  (lsu_wdata),
        .st_wdata_o  (wdata_d),
        .st_wmask_o  (wmask_d),
        .ld_off_i    (off_q),
        .ld_funct3_i (funct3_q),
        .ld_rdata_i  (mem_resp_rdata),
        .ld_data_o   (ld_data_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LSU_IDLE;
            req_vld_q   <= 1'b0;
            req_wen_q   <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wmask_q <= '0;
            off_q       <= '0;
            funct3_q    <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (lsu_valid) begin
                        if (access_err_d) begin
                            state_q <= LSU_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            state_q     <= LSU_REQ;
                            req_vld_q   <= 1'b1;
                            req_wen_q   <= lsu_wen;
                            req_addr_q  <= {lsu_addr[XLEN-1:3], 3'b000};
                            req_wdata_q <= wdata_d;
                            req_wmask_q <= wmask_d;
                            off_q       <= lsu_addr[2:0];
                            funct3_q    <= lsu_funct3;
                        end
                    end
                end
                LSU_REQ: begin
                    if (mem_req_ready) begin
                        req_vld_q <= 1'b0;
                        state_q   <= LSU_WAIT;
                    end
                end
                LSU_WAIT: begin
                    // Write acknowledges complete stores with no writeback data.
                    if (mem_resp_valid) begin
                        state_q <= LSU_DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b0;
                        rdata_q <= req_wen_q ? '0 : ld_data_d;
                    end
                end
                LSU_DONE: begin
                    state_q <= LSU_IDLE;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
                default: state_q <= LSU_IDLE;
            endcase
        end
    end

    assign lsu_rdata     = rdata_q;
    assign lsu_done      = done_q;
    assign lsu_err       = err_q;
    assign lsu_stall     = lsu_valid & ~done_q;
    assign mem_req_valid = req_vld_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wen   = req_wen_q;
    assign mem_req_wdata = req_wdata_q;
    assign mem_req_wmask = req_wmask_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed scenarios plus randomized accesses against a byte-level model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid;
    logic        lsu_wen;
    logic [2:0]  lsu_funct3;
    logic [63:0] lsu_addr;
    logic [63:0] lsu_wdata;
    logic [63:0] lsu_rdata;
    logic        lsu_done;
    logic        lsu_err;
    logic        lsu_stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // Results of the most recent run_access.
    int          r_done_cyc;
    int          r_done_abs;
    logic [63:0] r_rdata;
    logic        r_err;
    logic        r_req_seen;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [7:0]  r_mask;
    logic        r_wen;
    logic        r_stable;
    logic        r_stall_ok;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu #(.XLEN(64), .MASK_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .lsu_valid      (lsu_valid),
        .lsu_wen        (lsu_wen),
        .lsu_funct3     (lsu_funct3),
        .lsu_addr       (lsu_addr),
        .lsu_wdata      (lsu_wdata),
        .lsu_rdata      (lsu_rdata),
        .lsu_done       (lsu_done),
        .lsu_err        (lsu_err),
        .lsu_stall      (lsu_stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
    );

    // ---------------- reference model ----------------
    function automatic logic m_err(input logic wen, input logic [2:0] f3, input logic [63:0] addr);
        int  size;
        logic ill;
        size = 1 << f3[1:0];
        ill  = wen ? (f3 > 3'd3) : (f3 == 3'd7);
        return ill || ((int'(addr[2:0]) % size) != 0);
    endfunction

    function automatic logic [63:0] m_load(input logic [2:0] f3, input logic [63:0] addr,
                                           input logic [63:0] mem);
        int          size;
        int          off;
        logic [63:0] v;
        size = 1 << f3[1:0];
        off  = int'(addr[2:0]);
        v    = '0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = mem[8*(off+i) +: 8];
        if (!f3[2] && size < 8 && v[8*size-1])
            for (int i = size; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] addr, input logic [63:0] w);
        int          off;
        logic [63:0] v;
        off = int'(addr[2:0]);
        v   = '0;
        for (int j = 0; j < 8; j++)
            if (j >= off) v[8*j +: 8] = w[8*(j-off) +: 8];
        return v;
    endfunction

    function automatic logic [7:0] m_mask(input logic [2:0] f3, input logic [63:0] addr);
        int         off;
        int         size;
        logic [7:0] m;
        off  = int'(addr[2:0]);
        size = 1 << f3[1:0];
        m    = '0;
        for (int j = 0; j < 8; j++) m[j] = (j >= off) && (j < off + size);
        return m;
    endfunction

    // ---------------- driver + memory responder ----------------
    task automatic run_access(input logic wen, input logic [2:0] f3, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [63:0] mdata,
                              input int rdy_dly, input int rsp_dly, input logic noise);
        logic hs;
        int   rcnt;
        int   wcnt;
        hs = 1'b0; rcnt = 0; wcnt = 0;
        r_done_cyc = -1; r_done_abs = 0; r_rdata = '0; r_err = 1'b0; r_req_seen = 1'b0;
        r_addr = '0; r_wdata = '0; r_mask = '0; r_wen = 1'b0; r_stable = 1'b1; r_stall_ok = 1'b1;
        lsu_valid = 1'b1; lsu_wen = wen; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wdata;
        for (int c = 0; c < 40; c++) begin
            mem_req_ready  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_resp_valid = 1'b0;
            mem_resp_rdata = {$urandom, $urandom};
            if (mem_req_valid) begin
                if (!r_req_seen) begin
                    r_req_seen = 1'b1;
                    r_addr = mem_req_addr; r_wdata = mem_req_wdata;
                    r_mask = mem_req_wmask; r_wen = mem_req_wen;
                end else if (mem_req_addr !== r_addr || mem_req_wdata !== r_wdata ||
                             mem_req_wmask !== r_mask || mem_req_wen !== r_wen) begin
                    r_stable = 1'b0;
                end
                mem_req_ready = (rcnt >= rdy_dly);
                rcnt++;
            end
            if (hs) begin
                mem_resp_valid = (wcnt >= rsp_dly);
                wcnt++;
                if (mem_resp_valid) mem_resp_rdata = mdata;
            end else if (noise) begin
                mem_resp_valid = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (lsu_done) begin
                if (lsu_stall !== 1'b0) r_stall_ok = 1'b0;
                r_done_cyc = c; r_done_abs = cyc; r_rdata = lsu_rdata; r_err = lsu_err;
            end else if (lsu_stall !== 1'b1) begin
                r_stall_ok = 1'b0;
            end
            if (hs && mem_resp_valid) hs = 1'b0;
            else if (mem_req_valid && mem_req_ready) hs = 1'b1;
            @(posedge clk); #1;
            if (r_done_cyc >= 0) break;
        end
        lsu_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        lsu_valid = 1'b1; lsu_wen = 1'b1; lsu_funct3 = 3'b011;
        lsu_addr = 64'h8000_0008; lsu_wdata = {$urandom, $urandom};
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = {$urandom, $urandom};
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (mem_req_valid !== 1'b0) $display("FAIL reset_req_valid got=%b exp=0", mem_req_valid); else passed++;
        total++; if (mem_req_wen !== 1'b0) $display("FAIL reset_req_wen got=%b exp=0", mem_req_wen); else passed++;
        total++; if (mem_req_wmask !== 8'h00) $display("FAIL reset_req_wmask got=%h exp=00", mem_req_wmask); else passed++;
        total++; if (mem_req_addr !== 64'h0) $display("FAIL reset_req_addr got=%h exp=0", mem_req_addr); else passed++;
        total++; if (mem_req_wdata !== 64'h0) $display("FAIL reset_req_wdata got=%h exp=0", mem_req_wdata); else passed++;
        total++; if (lsu_done !== 1'b0) $display("FAIL reset_done got=%b exp=0", lsu_done); else passed++;
        total++; if (lsu_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", lsu_err); else passed++;
        total++; if (lsu_rdata !== 64'h0) $display("FAIL reset_rdata got=%h exp=0", lsu_rdata); else passed++;
        @(posedge clk); #1;
        rst = 1'b0; lsu_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lw_zero_wait();
        run_access(1'b0, 3'b010, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 0, 0, 1'b0);
        total++; if (r_rdata !== 64'hFFFF_FFFF_8765_4321) $display("FAIL lw_rdata got=%h exp=ffffffff87654321", r_rdata); else passed++;
        total++; if (r_done_cyc !== 3) $display("FAIL lw_latency got=%0d exp=3", r_done_cyc); else passed++;
        total++; if (r_err !== 1'b0) $display("FAIL lw_err got=%b exp=0", r_err); else passed++;
        total++; if (r_addr !== 64'h8000_0000) $display("FAIL lw_req_addr got=%h exp=80000000", r_addr); else passed++;
        total++; if (r_stall_ok !== 1'b1) $display("FAIL lw_stall got=%b exp=1", r_stall_ok); else passed++;
    endtask

    task automatic test_lbu_ready_delay();
        run_access(1'b0, 3'b100, 64'h8000_0007, 64'h0, 64'hAB00_0000_0000_0000, 2, 0, 1'b0);
        total++; if (r_rdata !== 64'h0000_0000_0000_00AB) $display("FAIL lbu_rdata got=%h exp=ab", r_rdata); else passed++;
        total++; if (r_done_cyc !== 5) $display("FAIL lbu_latency got=%0d exp=5", r_done_cyc); else passed++;
        total++; if (r_stable !== 1'b1) $display("FAIL lbu_req_stable got=%b exp=1", r_stable); else passed++;
    endtask

    task automatic test_sh();
        run_access(1'b1, 3'b001, 64'h8000_0002, 64'h1234, {$urandom, $urandom}, 0, 1, 1'b0);
        total++; if (r_wdata !== 64'h0000_0000_1234_0000) $display("FAIL sh_wdata got=%h exp=12340000", r_wdata); else passed++;
        total++; if (r_mask !== 8'h0C) $display("FAIL sh_wmask got=%h exp=0c", r_mask); else passed++;
        total++; if (r_addr !== 64'h8000_0000) $display("FAIL sh_req_addr got=%h exp=80000000", r_addr); else passed++;
        total++; if (r_wen !== 1'b1) $display("FAIL sh_req_wen got=%b exp=1", r_wen); else passed++;
        total++; if (r_rdata !== 64'h0) $display("FAIL sh_rdata got=%h exp=0", r_rdata); else passed++;
        total++; if (r_done_cyc !== 4) $display("FAIL sh_latency got=%0d exp=4", r_done_cyc); else passed++;
    endtask

    task automatic test_misaligned_ld();
        run_access(1'b0, 3'b011, 64'h8000_0004, 64'h0, {$urandom, $urandom}, 0, 0, 1'b0);
        total++; if (r_req_seen !== 1'b0) $display("FAIL misal_req_valid got=%b exp=0", r_req_seen); else passed++;
        total++; if (r_done_cyc !== 1) $display("FAIL misal_latency got=%0d exp=1", r_done_cyc); else passed++;
        total++; if (r_err !== 1'b1) $display("FAIL misal_err got=%b exp=1", r_err); else passed++;
        total++; if (r_rdata !== 64'h0) $display("FAIL misal_rdata got=%h exp=0", r_rdata); else passed++;
    endtask

    task automatic test_reset_in_wait();
        logic        seen_done;
        logic        seen_req;
        logic [63:0] md;
        lsu_valid = 1'b1; lsu_wen = 1'b0; lsu_funct3 = 3'b011;
        lsu_addr = 64'h8000_0010; lsu_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (mem_req_valid !== 1'b1) $display("FAIL rstwait_req got=%b exp=1", mem_req_valid); else passed++;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; lsu_valid = 1'b0;
        @(posedge clk); #1;
        mem_resp_valid = 1'b1; mem_resp_rdata = {$urandom, $urandom};
        seen_done = 1'b0; seen_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (lsu_done) seen_done = 1'b1;
            if (mem_req_valid) seen_req = 1'b1;
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
        end
        total++; if (seen_done !== 1'b0) $display("FAIL rstwait_late_done got=%b exp=0", seen_done); else passed++;
        total++; if (seen_req !== 1'b0) $display("FAIL rstwait_req_after got=%b exp=0", seen_req); else passed++;
        md = {$urandom, $urandom};
        run_access(1'b0, 3'b011, 64'h8000_0000, 64'h0, md, 0, 0, 1'b0);
        total++; if (r_rdata !== md) $display("FAIL rstwait_next_rdata got=%h exp=%h", r_rdata, md); else passed++;
        total++; if (r_done_cyc !== 3) $display("FAIL rstwait_next_latency got=%0d exp=3", r_done_cyc); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] m0;
        logic [63:0] m1;
        int          d0;
        m0 = {$urandom, $urandom};
        m1 = {$urandom, $urandom};
        run_access(1'b0, 3'b011, 64'h8000_0100, 64'h0, m0, 0, 0, 1'b0);
        d0 = r_done_abs;
        total++; if (r_done_cyc !== 3) $display("FAIL b2b_first_latency got=%0d exp=3", r_done_cyc); else passed++;
        total++; if (r_rdata !== m0) $display("FAIL b2b_first_rdata got=%h exp=%h", r_rdata, m0); else passed++;
        run_access(1'b0, 3'b011, 64'h8000_0108, 64'h0, m1, 0, 0, 1'b0);
        total++; if (r_done_abs - d0 !== 4) $display("FAIL b2b_gap got=%0d exp=4", r_done_abs - d0); else passed++;
        total++; if (r_rdata !== m1) $display("FAIL b2b_second_rdata got=%h exp=%h", r_rdata, m1); else passed++;
        total++; if (r_addr !== 64'h8000_0108) $display("FAIL b2b_second_addr got=%h exp=80000108", r_addr); else passed++;
        total++; if (r_stall_ok !== 1'b1) $display("FAIL b2b_stall got=%b exp=1", r_stall_ok); else passed++;
    endtask

    task automatic test_random();
        logic        wen;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wd;
        logic [63:0] md;
        logic        e;
        int          rd;
        int          sd;
        int          sz;
        for (int n = 0; n < 60; n++) begin
            wen  = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = 64'h8000_0000 + 64'($urandom_range(0, 4095));
            sz   = 1 << f3[1:0];
            if ($urandom_range(0, 1) == 1) addr = addr & ~64'(sz - 1);
            wd   = {$urandom, $urandom};
            md   = {$urandom, $urandom};
            rd   = int'($urandom_range(0, 3));
            sd   = int'($urandom_range(0, 3));
            e    = m_err(wen, f3, addr);
            run_access(wen, f3, addr, wd, md, rd, sd, 1'b1);
            total++; if (r_err !== e) $display("FAIL rnd%0d_err got=%b exp=%b", n, r_err, e); else passed++;
            total++;
            if (r_done_cyc !== (e ? 1 : 3 + rd + sd))
                $display("FAIL rnd%0d_latency got=%0d exp=%0d", n, r_done_cyc, e ? 1 : 3 + rd + sd);
            else passed++;
            total++;
            if (r_rdata !== ((e || wen) ? 64'h0 : m_load(f3, addr, md)))
                $display("FAIL rnd%0d_rdata got=%h exp=%h", n, r_rdata, (e || wen) ? 64'h0 : m_load(f3, addr, md));
            else passed++;
            if (e) begin
                total++; if (r_req_seen !== 1'b0) $display("FAIL rnd%0d_err_req got=%b exp=0", n, r_req_seen); else passed++;
            end else begin
                total++; if (r_addr !== {addr[63:3], 3'b000}) $display("FAIL rnd%0d_addr got=%h exp=%h", n, r_addr, {addr[63:3], 3'b000}); else passed++;
                total++; if (r_wen !== wen) $display("FAIL rnd%0d_wen got=%b exp=%b", n, r_wen, wen); else passed++;
                total++; if (r_stable !== 1'b1) $display("FAIL rnd%0d_stable got=%b exp=1", n, r_stable); else passed++;
                if (wen) begin
                    total++; if (r_wdata !== m_wdata(addr, wd)) $display("FAIL rnd%0d_wdata got=%h exp=%h", n, r_wdata, m_wdata(addr, wd)); else passed++;
                    total++; if (r_mask !== m_mask(f3, addr)) $display("FAIL rnd%0d_wmask got=%h exp=%h", n, r_mask, m_mask(f3, addr)); else passed++;
                end
            end
            total++; if (r_stall_ok !== 1'b1) $display("FAIL rnd%0d_stall got=%b exp=1", n, r_stall_ok); else passed++;
        end
    endtask

    initial begin
        rst = 1'b0; lsu_valid = 1'b0; lsu_wen = 1'b0; lsu_funct3 = '0;
        lsu_addr = '0; lsu_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        @(posedge clk); #1;
        test_reset();
        test_lw_zero_wait();
        test_lbu_ready_delay();
        test_sh();
        test_misaligned_ld();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=%0d cycles exp=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
